// File: rtl/timepulse_monitor.sv
// Receive-side checker for the twelve-step timepulse ring (T01..T12).
// Tracks ring order, one-hot shape and stalls, counts MCTs, and issues GOJ1 on faults.
//
// Ports:
//   SIM_CLK    system clock, all state changes on the rising edge
//   RESET      asynchronous active-high reset
//   TP_STB     one-cycle strobe: TP has advanced
//   TP[11:0]   timepulse vector, bit 0 = T01 .. bit 11 = T12
//   STOP       ring legitimately halted; freezes the stall counter
//   ALM_CLR    clears sticky alarms and the error code
//   LOCKED     monitor is locked to the ring
//   MCT_COUNT  completed memory cycles, wraps
//   RING_ERR   sticky sequence / one-hot fault flag
//   STALL_ALM  sticky stall fault flag
//   ERR_CODE   last fault: 0 none, 1 sequence, 2 not one-hot, 3 stall
//   FAULT_CNT  saturating fault count
//   GOJ1       restart request toward the timer
module timepulse_monitor #(
   parameter int STALL_LIMIT = 64,
   parameter int GOJ_WIDTH   = 4,
   parameter int CNT_W       = 16
) (
   input  logic             SIM_CLK,
   input  logic             RESET,
   input  logic             TP_STB,
   input  logic [11:0]      TP,
   input  logic             STOP,
   input  logic             ALM_CLR,
   output logic             LOCKED,
   output logic [CNT_W-1:0] MCT_COUNT,
   output logic             RING_ERR,
   output logic             STALL_ALM,
   output logic [1:0]       ERR_CODE,
   output logic [7:0]       FAULT_CNT,
   output logic             GOJ1
);

   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam int GW = $clog2(GOJ_WIDTH + 1);

   typedef enum logic [1:0] {
      SYNC,
      LOCK,
      FAULT
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [11:0]     expect_q;
   logic [11:0]     expect_nx;
   logic [SW-1:0]   stall_q;
   logic [SW-1:0]   stall_nx;
   logic [GW-1:0]   goj_q;
   logic [GW-1:0]   goj_nx;
   logic            tp_onehot;
   logic [1:0]      fault_code;
   logic            mct_inc;

   always_comb begin
      // x & (x-1) clears the lowest set bit: zero only for a single bit
      tp_onehot  = (TP != 12'h000) && ((TP & (TP - 12'd1)) == 12'h000);
      state_nx   = state;
      expect_nx  = expect_q;
      stall_nx   = stall_q;
      goj_nx     = goj_q;
      fault_code = 2'd0;
      mct_inc    = 1'b0;

      unique case (state)
         SYNC: begin
            stall_nx = '0;
            if (TP_STB && TP == 12'h001) begin
               state_nx  = LOCK;
               expect_nx = 12'h002;
            end
         end
         LOCK: begin
            if (TP_STB) begin
               stall_nx = '0;
               if (!tp_onehot) begin
                  fault_code = 2'd2;
               end else if (TP != expect_q) begin
                  fault_code = 2'd1;
               end else begin
                  expect_nx = {TP[10:0], TP[11]};
                  mct_inc   = TP[11];
               end
            end else if (!STOP) begin
               if (stall_q == SW'(STALL_LIMIT - 1)) begin
                  fault_code = 2'd3;
               end else begin
                  stall_nx = stall_q + SW'(1);
               end
            end
         end
         FAULT: begin
            goj_nx = goj_q - GW'(1);
            if (goj_q <= GW'(1)) begin
               state_nx = SYNC;
               goj_nx   = '0;
            end
         end
         default: begin
            state_nx = SYNC;
         end
      endcase

      if (fault_code != 2'd0) begin
         state_nx = FAULT;
         goj_nx   = GW'(GOJ_WIDTH);
      end
   end

   always_ff @(posedge SIM_CLK or posedge RESET) begin
      if (RESET) begin
         state     <= SYNC;
         expect_q  <= 12'h002;
         stall_q   <= '0;
         goj_q     <= '0;
         LOCKED    <= 1'b0;
         MCT_COUNT <= '0;
         RING_ERR  <= 1'b0;
         STALL_ALM <= 1'b0;
         ERR_CODE  <= 2'd0;
         FAULT_CNT <= 8'd0;
         GOJ1      <= 1'b0;
      end else begin
         state    <= state_nx;
         expect_q <= expect_nx;
         stall_q  <= stall_nx;
         goj_q    <= goj_nx;
         LOCKED   <= (state_nx == LOCK);
         GOJ1     <= (state_nx == FAULT);
         if (mct_inc) begin
            MCT_COUNT <= MCT_COUNT + CNT_W'(1);
         end
         if (ALM_CLR) begin
            RING_ERR  <= 1'b0;
            STALL_ALM <= 1'b0;
            ERR_CODE  <= 2'd0;
         end
         // a fault in the same cycle as ALM_CLR overrides the clear
         if (fault_code != 2'd0) begin
            ERR_CODE <= fault_code;
            if (fault_code == 2'd3) begin
               STALL_ALM <= 1'b1;
            end else begin
               RING_ERR <= 1'b1;
            end
            if (FAULT_CNT != 8'hFF) begin
               FAULT_CNT <= FAULT_CNT + 8'd1;
            end
         end
      end
   end

endmodule
